// File: rtl/l2todr_req_tracker_pkg.sv
// l2todr_req_tracker_pkg: shared scmem request types for the L2-to-directory path
package l2todr_req_tracker_pkg;
  localparam int L2_REQID_W = 6;
  typedef logic [4:0] SC_nodeid_type;
  typedef logic [L2_REQID_W-1:0] L2_reqid_type;
  typedef logic [2:0] SC_cmd_type;
  typedef logic [48:0] SC_paddr_type;
  typedef struct packed {
    SC_nodeid_type nid;
    L2_reqid_type l2id;
    SC_cmd_type cmd;
    SC_paddr_type paddr;
  } I_l2todr_req_type;
endpackage

// File: rtl/l2todr_req_tracker_fifo.sv
// l2todr_req_fifo: flop FIFO with valid/retry on both sides, full/empty from wrap-bit pointers
module l2todr_req_fifo
  import l2todr_req_tracker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_retry,
  input  I_l2todr_req_type in_data,
  output logic             out_valid,
  input  logic             out_retry,
  output I_l2todr_req_type out_data
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  I_l2todr_req_type mem_q [DEPTH];
  I_l2todr_req_type mem_d [DEPTH];
  logic push, pop;
  assign in_retry = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign out_valid = wr_q != rd_q;
  assign out_data = mem_q[rd_q[AW-1:0]];
  assign push = in_valid & ~in_retry;
  assign pop = out_valid & ~out_retry;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = in_data;
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/l2todr_req_tracker.sv
// l2todr_req_tracker: buffers L2 miss requests to the directory and tracks in-flight l2ids
module l2todr_req_tracker
  import l2todr_req_tracker_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          l2_req_valid,
  output logic          l2_req_retry,
  input  SC_nodeid_type l2_req_nid,
  input  L2_reqid_type  l2_req_l2id,
  input  SC_cmd_type    l2_req_cmd,
  input  SC_paddr_type  l2_req_paddr,
  output logic          l2todr_req_valid,
  input  logic          l2todr_req_retry,
  output SC_nodeid_type l2todr_req_nid,
  output L2_reqid_type  l2todr_req_l2id,
  output SC_cmd_type    l2todr_req_cmd,
  output SC_paddr_type  l2todr_req_paddr,
  input  logic          drtol2_snack_valid,
  input  logic          drtol2_snack_retry,
  input  L2_reqid_type  drtol2_snack_l2id,
  output logic [6:0]    outstanding_cnt,
  output logic          err_spurious_snack
);
  logic [63:0] bitmap_q, bitmap_d;
  logic [6:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic fifo_full, accept, snack_fire, snack_hit;
  I_l2todr_req_type head;
  // retry uses registered state only, so a same-cycle snack frees its id one cycle later
  assign l2_req_retry = fifo_full | bitmap_q[l2_req_l2id] | (cnt_q == 7'(MAX_OUTSTANDING));
  assign accept = l2_req_valid & ~l2_req_retry;
  assign snack_fire = drtol2_snack_valid & ~drtol2_snack_retry;
  assign snack_hit = snack_fire & bitmap_q[drtol2_snack_l2id];
  l2todr_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .in_valid(accept),
    .in_retry(fifo_full),
    .in_data('{nid: l2_req_nid, l2id: l2_req_l2id, cmd: l2_req_cmd, paddr: l2_req_paddr}),
    .out_valid(l2todr_req_valid),
    .out_retry(l2todr_req_retry),
    .out_data(head)
  );
  assign l2todr_req_nid = head.nid;
  assign l2todr_req_l2id = head.l2id;
  assign l2todr_req_cmd = head.cmd;
  assign l2todr_req_paddr = head.paddr;
  assign outstanding_cnt = cnt_q;
  assign err_spurious_snack = err_q;
  always_comb begin
    bitmap_d = bitmap_q;
    if (accept) bitmap_d[l2_req_l2id] = 1'b1;
    if (snack_hit) bitmap_d[drtol2_snack_l2id] = 1'b0;
    cnt_d = cnt_q + 7'(accept) - 7'(snack_hit);
    err_d = err_q | (snack_fire & ~snack_hit);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitmap_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_l2todr_req_tracker.sv
// tb_l2todr_req_tracker: directed, table-driven and randomized model-checked bench for the tracker
module tb_l2todr_req_tracker;
  import l2todr_req_tracker_pkg::*;
  logic clk = 0, reset = 0;
  logic rv = 0, rretry, dr = 0, ov, sv = 0, sr = 0, err;
  logic [4:0] nid = 0, onid;
  logic [5:0] rid = 0, oid, sid = 0;
  logic [2:0] cmd = 0, ocmd;
  logic [48:0] paddr = 0, opaddr;
  logic [6:0] cnt;
  logic b_rv = 0, b_rretry, b_dr = 0, b_ov, b_sv = 0, b_err;
  logic [5:0] b_rid = 0, b_sid = 0, b_oid;
  logic [4:0] b_onid;
  logic [2:0] b_ocmd;
  logic [48:0] b_opaddr;
  logic [6:0] b_cnt;
  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  l2todr_req_tracker u_dut (
    .clk(clk), .reset(reset),
    .l2_req_valid(rv), .l2_req_retry(rretry), .l2_req_nid(nid), .l2_req_l2id(rid),
    .l2_req_cmd(cmd), .l2_req_paddr(paddr),
    .l2todr_req_valid(ov), .l2todr_req_retry(dr), .l2todr_req_nid(onid), .l2todr_req_l2id(oid),
    .l2todr_req_cmd(ocmd), .l2todr_req_paddr(opaddr),
    .drtol2_snack_valid(sv), .drtol2_snack_retry(sr), .drtol2_snack_l2id(sid),
    .outstanding_cnt(cnt), .err_spurious_snack(err)
  );

  l2todr_req_tracker #(.MAX_OUTSTANDING(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .l2_req_valid(b_rv), .l2_req_retry(b_rretry), .l2_req_nid(5'd1), .l2_req_l2id(b_rid),
    .l2_req_cmd(3'd1), .l2_req_paddr(49'h2000),
    .l2todr_req_valid(b_ov), .l2todr_req_retry(b_dr), .l2todr_req_nid(b_onid), .l2todr_req_l2id(b_oid),
    .l2todr_req_cmd(b_ocmd), .l2todr_req_paddr(b_opaddr),
    .drtol2_snack_valid(b_sv), .drtol2_snack_retry(1'b0), .drtol2_snack_l2id(b_sid),
    .outstanding_cnt(b_cnt), .err_spurious_snack(b_err)
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rv; logic [5:0] rid; logic sv; logic [5:0] sid; logic sr; logic dr;
    logic e_retry; logic [6:0] e_cnt; logic e_ov; logic e_err;
  } vec_t;
  vec_t vt[9];

  I_l2todr_req_type mq[$];
  bit mbm[64];
  bit merr;

  function automatic int pop_model();
    int c = 0;
    for (int i = 0; i < 64; i++) c += mbm[i];
    return c;
  endfunction

  initial begin
    vt[0] = '{1, 2, 0, 0, 0, 1, 0, 1, 1, 1};
    vt[1] = '{1, 2, 0, 0, 0, 1, 1, 1, 1, 1};
    vt[2] = '{1, 3, 1, 2, 0, 1, 0, 1, 1, 1};
    vt[3] = '{0, 0, 1, 33, 0, 0, 0, 1, 1, 1};
    vt[4] = '{0, 0, 1, 3, 0, 0, 0, 0, 0, 1};
    vt[5] = '{1, 9, 0, 0, 0, 1, 0, 1, 1, 1};
    vt[6] = '{0, 0, 1, 9, 1, 1, 0, 1, 1, 1};
    vt[7] = '{0, 0, 1, 9, 0, 0, 0, 0, 0, 1};
    vt[8] = '{0, 9, 0, 0, 0, 0, 0, 0, 0, 1};

    #12;
    chk("rst_valid", ov, 0);
    chk("rst_retry", rretry, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_err", err, 0);
    reset = 1;
    tick();

    // cap of two outstanding on the second instance
    b_rv = 1; b_rid = 7; tick();
    b_rid = 8; tick();
    b_rid = 9; #1;
    chk("cap_retry", b_rretry, 1);
    chk("cap_cnt", b_cnt, 2);
    tick(); tick();
    chk("cap_drained", b_ov, 0);
    chk("cap_retry_hold", b_rretry, 1);
    b_sv = 1; b_sid = 7; #1;
    chk("cap_retry_snack_cycle", b_rretry, 1);
    tick();
    b_sv = 0; #1;
    chk("cap_retry_freed", b_rretry, 0);
    chk("cap_cnt_freed", b_cnt, 1);
    tick();
    b_rv = 0; #1;
    chk("cap_cnt_after", b_cnt, 2);
    chk("cap_retry_after", b_rretry, 1);

    // single request through
    rv = 1; rid = 5; nid = 3; cmd = 2; paddr = 49'h1000; dr = 0; #1;
    chk("t1_retry", rretry, 0);
    tick();
    rv = 0;
    chk("t1_valid", ov, 1);
    chk("t1_l2id", oid, 5);
    chk("t1_nid", onid, 3);
    chk("t1_cmd", ocmd, 2);
    chk("t1_paddr", opaddr, 49'h1000);
    chk("t1_cnt", cnt, 1);
    rv = 1; sv = 1; sid = 5; #1;
    chk("t2_dup_retry", rretry, 1);
    tick();
    sv = 0; #1;
    chk("t2_retry_freed", rretry, 0);
    chk("t2_cnt", cnt, 0);
    chk("t2_valid", ov, 0);
    rv = 0;

    // fill under directory back-pressure, then drain in order
    dr = 1;
    for (int i = 1; i <= 4; i++) begin
      rv = 1; rid = 6'(i); #1;
      chk("t3_push_retry", rretry, 0);
      tick();
    end
    rid = 5; #1;
    chk("t3_full_retry", rretry, 1);
    rv = 0;
    chk("t3_cnt", cnt, 4);
    dr = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t3_valid", ov, 1);
      chk("t3_order", oid, 64'(i));
      sv = 1; sid = 6'(i);
      tick();
    end
    sv = 0; #1;
    chk("t3_empty", ov, 0);
    chk("t3_cnt_done", cnt, 0);

    // spurious snack
    sv = 1; sid = 33; tick();
    sv = 0; #1;
    chk("t5_err", err, 1);
    chk("t5_cnt", cnt, 0);
    tick();
    chk("t5_err_sticky", err, 1);

    foreach (vt[k]) begin
      rv = vt[k].rv; rid = vt[k].rid; sv = vt[k].sv; sid = vt[k].sid; sr = vt[k].sr; dr = vt[k].dr;
      #1;
      chk($sformatf("vec%0d_retry", k), rretry, vt[k].e_retry);
      tick();
      chk($sformatf("vec%0d_cnt", k), cnt, vt[k].e_cnt);
      chk($sformatf("vec%0d_valid", k), ov, vt[k].e_ov);
      chk($sformatf("vec%0d_err", k), err, vt[k].e_err);
    end
    rv = 0; sv = 0; sr = 0;

    // simultaneous accept and completion, then reset mid-burst
    dr = 1; rv = 1; rid = 2; tick();
    rid = 3; sv = 1; sid = 2; #1;
    chk("t6_retry", rretry, 0);
    tick();
    sv = 0; #1;
    chk("t6_cnt_same", cnt, 1);
    rid = 4; tick();
    rid = 5; tick();
    rid = 6; #3;
    reset = 0; #1;
    chk("t6_rst_valid", ov, 0);
    chk("t6_rst_retry", rretry, 0);
    chk("t6_rst_cnt", cnt, 0);
    chk("t6_rst_err", err, 0);
    rv = 0;
    @(negedge clk);
    reset = 1;
    tick();

    // randomized run against the behavioural model
    merr = 0;
    for (int c = 0; c < 400; c++) begin
      int pc;
      bit full, eretry, acc, pop, fire, hit;
      I_l2todr_req_type r;
      rv = $urandom_range(0, 3) != 0;
      rid = 6'($urandom_range(0, 31));
      nid = 5'($urandom); cmd = 3'($urandom); paddr = {17'($urandom), 32'($urandom)};
      dr = $urandom_range(0, 2) == 0;
      sv = $urandom_range(0, 2) == 0;
      sr = $urandom_range(0, 3) == 0;
      sid = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) != 0) begin
        int s = $urandom_range(0, 63);
        for (int j = 0; j < 64; j++) if (mbm[(s + j) % 64]) begin sid = 6'((s + j) % 64); break; end
      end
      #1;
      pc = pop_model();
      full = mq.size() == 4;
      eretry = full || mbm[rid] || pc == 16;
      chk("rnd_retry", rretry, eretry);
      chk("rnd_valid", ov, mq.size() != 0);
      if (mq.size() != 0) chk("rnd_head", {onid, oid, ocmd, opaddr}, mq[0]);
      chk("rnd_cnt", cnt, pc);
      chk("rnd_err", err, merr);
      acc = rv && !eretry;
      pop = mq.size() != 0 && !dr;
      fire = sv && !sr;
      hit = fire && mbm[sid];
      if (fire && !hit) merr = 1;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        r = '{nid: nid, l2id: rid, cmd: cmd, paddr: paddr};
        mq.push_back(r);
        mbm[rid] = 1;
      end
      if (hit) mbm[sid] = 0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
